// File: rtl/call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : call_stack_ctrl
// Description : Controller for the return-address stack RAM. Arbitrates
//               push/pop requests from the core (call/ret) and the interrupt
//               unit (entry/return), owns the downward-growing stack pointer,
//               drives the RAM ports and returns popped addresses.
// Ports       : clk/rst (async, active-low)         - clock and reset
//               core_call/core_ret/core_wdata/core_ready - core request port
//               irq_push/irq_pop/irq_wdata/irq_ready     - interrupt port
//               mem_we/mem_addr/mem_wdata/mem_rdata      - stack RAM port
//               pop_data/pop_valid/pop_dst               - pop result
//               sp/empty/full                            - stack status
//               ovf_err/unf_err/err_clr                  - sticky errors
// Revision    : 1.0 - initial release
// ============================================================================
module call_stack_ctrl #(
  parameter int unsigned           DW       = 19,
  parameter int unsigned           AW       = 8,
  parameter logic [AW-1:0]         SP_INIT  = AW'('h38),
  parameter logic [AW-1:0]         SP_LIMIT = AW'('h00)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_call,
  input  logic          core_ret,
  input  logic [DW-1:0] core_wdata,
  output logic          core_ready,
  input  logic          irq_push,
  input  logic          irq_pop,
  input  logic [DW-1:0] irq_wdata,
  output logic          irq_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          pop_dst,
  output logic [AW-1:0] sp,
  output logic          empty,
  output logic          full,
  output logic          ovf_err,
  output logic          unf_err,
  input  logic          err_clr
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RD   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [DW-1:0] pop_data_q, pop_data_d;
  logic          pop_valid_q;
  logic          pop_dst_q;
  logic          rd_empty_q;   // pop was accepted on an empty stack
  logic          ovf_q, unf_q;

  logic          idle;
  logic          irq_req, core_req;
  logic          op_valid, op_push, op_dst;
  logic [DW-1:0] op_wdata;

  assign idle     = (state_q == ST_IDLE);
  assign empty    = (sp_q == SP_INIT);
  assign full     = (sp_q == SP_LIMIT);
  assign irq_req  = irq_push | irq_pop;
  assign core_req = core_call | core_ret;

  // Accepted operation this cycle: irq beats core, push beats pop.
  assign op_valid = idle && (irq_req || core_req);
  assign op_push  = irq_req ? irq_push : core_call;
  assign op_dst   = irq_req;
  assign op_wdata = irq_req ? irq_wdata : core_wdata;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (op_valid && !op_push) state_d = ST_RD;
      ST_RD:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    irq_ready  = idle;
    core_ready = idle && !irq_req;
    mem_we     = 1'b0;
    mem_addr   = sp_q;
    mem_wdata  = op_wdata;
    if (op_valid && op_push) begin
      mem_addr = sp_q - AW'(1);
      mem_we   = !full;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    sp_d       = sp_q;
    pop_data_d = pop_data_q;
    if (op_valid && op_push && !full) begin
      sp_d = sp_q - AW'(1);
    end
    if (state_q == ST_RD) begin
      // mem_rdata only ever reaches a register, never an output directly.
      pop_data_d = rd_empty_q ? '0 : mem_rdata;
      if (!rd_empty_q) sp_d = sp_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q        <= SP_INIT;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      pop_dst_q   <= 1'b0;
      rd_empty_q  <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= (state_q == ST_RD);
      if (op_valid && !op_push) begin
        pop_dst_q  <= op_dst;
        rd_empty_q <= empty;
      end
      // Clear wins over a same-cycle error.
      if (err_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (op_valid && op_push && full)   ovf_q <= 1'b1;
        if (op_valid && !op_push && empty) unf_q <= 1'b1;
      end
    end
  end

  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign pop_dst   = pop_dst_q;
  assign sp        = sp_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_call_stack_ctrl
// Description : Directed self-checking bench for call_stack_ctrl. Expected pop
//               results are queued when a pop is issued and compared when the
//               DUT pulses pop_valid. A second instance with a tiny stack
//               covers the full/overflow boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_call_stack_ctrl;

  localparam int DW = 19;
  localparam int AW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          dst;
  } pop_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- main instance (SP_INIT = 8'h38) -------------------------
  logic          core_call = 0, core_ret = 0, irq_push = 0, irq_pop = 0, err_clr = 0;
  logic [DW-1:0] core_wdata = '0, irq_wdata = '0;
  logic          core_ready, irq_ready, mem_we, pop_valid, pop_dst, empty, full;
  logic          ovf_err, unf_err;
  logic [AW-1:0] mem_addr, sp;
  logic [DW-1:0] mem_wdata, mem_rdata, pop_data;
  logic [DW-1:0] ram [256];

  call_stack_ctrl #(.DW(DW), .AW(AW), .SP_INIT(8'h38), .SP_LIMIT(8'h00)) u_dut (
    .clk(clk), .rst(rst),
    .core_call(core_call), .core_ret(core_ret), .core_wdata(core_wdata), .core_ready(core_ready),
    .irq_push(irq_push), .irq_pop(irq_pop), .irq_wdata(irq_wdata), .irq_ready(irq_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pop_data(pop_data), .pop_valid(pop_valid), .pop_dst(pop_dst),
    .sp(sp), .empty(empty), .full(full),
    .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- small instance (SP_INIT = 8'h02) ------------------------
  logic          s_core_call = 0, s_core_ret = 0;
  logic [DW-1:0] s_core_wdata = '0;
  logic          s_core_ready, s_irq_ready, s_mem_we, s_pop_valid, s_pop_dst, s_empty, s_full;
  logic          s_ovf_err, s_unf_err;
  logic [AW-1:0] s_mem_addr, s_sp;
  logic [DW-1:0] s_mem_wdata, s_mem_rdata, s_pop_data;
  logic [DW-1:0] s_ram [256];

  call_stack_ctrl #(.DW(DW), .AW(AW), .SP_INIT(8'h02), .SP_LIMIT(8'h00)) u_small (
    .clk(clk), .rst(rst),
    .core_call(s_core_call), .core_ret(s_core_ret), .core_wdata(s_core_wdata), .core_ready(s_core_ready),
    .irq_push(1'b0), .irq_pop(1'b0), .irq_wdata('0), .irq_ready(s_irq_ready),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata),
    .pop_data(s_pop_data), .pop_valid(s_pop_valid), .pop_dst(s_pop_dst),
    .sp(s_sp), .empty(s_empty), .full(s_full),
    .ovf_err(s_ovf_err), .unf_err(s_unf_err), .err_clr(1'b0)
  );

  always @(posedge clk) begin
    if (s_mem_we) s_ram[s_mem_addr] <= s_mem_wdata;
    s_mem_rdata <= s_ram[s_mem_addr];
  end

  // ---------------- checking ------------------------------------------------
  pop_exp_t exp_q   [$];
  pop_exp_t s_exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pop_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_valid", 32'(pop_valid), 32'd0);
      end else begin
        pop_exp_t e;
        e = exp_q.pop_front();
        chk("pop_data", 32'(pop_data), 32'(e.data));
        chk("pop_dst",  32'(pop_dst),  32'(e.dst));
      end
    end
    if (s_pop_valid === 1'b1) begin
      if (s_exp_q.size() == 0) begin
        chk("s_unexpected_pop_valid", 32'(s_pop_valid), 32'd0);
      end else begin
        pop_exp_t e;
        e = s_exp_q.pop_front();
        chk("s_pop_data", 32'(s_pop_data), 32'(e.data));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one pop on the main instance and wait out the RD cycle.
  task automatic do_pop(input logic is_irq, input logic [DW-1:0] data);
    if (is_irq) irq_pop = 1'b1; else core_ret = 1'b1;
    exp_q.push_back('{data: data, dst: is_irq});
    tick();
    irq_pop  = 1'b0;
    core_ret = 1'b0;
    tick();
  endtask

  task automatic s_push(input logic [DW-1:0] data);
    s_core_call  = 1'b1;
    s_core_wdata = data;
    tick();
    s_core_call  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // 1: reset state, then a core push
    chk("reset_sp",        32'(sp),        32'h38);
    chk("reset_empty",     32'(empty),     32'd1);
    chk("reset_pop_valid", 32'(pop_valid), 32'd0);
    chk("reset_pop_data",  32'(pop_data),  32'd0);
    chk("reset_errs",      32'({ovf_err, unf_err}), 32'd0);
    chk("reset_irq_ready", 32'(irq_ready), 32'd1);
    core_call = 1'b1; core_wdata = 19'h1234;
    #1;
    chk("push1_we",    32'(mem_we),     32'd1);
    chk("push1_addr",  32'(mem_addr),   32'h37);
    chk("push1_wdata", 32'(mem_wdata),  32'h1234);
    chk("push1_ready", 32'(core_ready), 32'd1);
    tick();
    core_call = 1'b0;
    #1;
    chk("push1_sp",    32'(sp),     32'h37);
    chk("idle_we",     32'(mem_we), 32'd0);

    // 2: core pop of the pushed address
    core_ret = 1'b1;
    #1;
    chk("pop1_addr",  32'(mem_addr),   32'h37);
    chk("pop1_ready", 32'(core_ready), 32'd1);
    exp_q.push_back('{data: 19'h1234, dst: 1'b0});
    tick();
    core_ret = 1'b0;
    #1;
    chk("rd_core_ready", 32'(core_ready), 32'd0);
    chk("rd_irq_ready",  32'(irq_ready),  32'd0);
    tick();
    chk("pop1_valid", 32'(pop_valid), 32'd1);
    chk("pop1_sp",    32'(sp),        32'h38);
    chk("t2_ready",   32'(irq_ready), 32'd1);

    // 3: simultaneous irq_push and core_call -> irq first
    irq_push = 1'b1; irq_wdata = 19'h2222;
    core_call = 1'b1; core_wdata = 19'h3333;
    #1;
    chk("arb_irq_ready",  32'(irq_ready),  32'd1);
    chk("arb_core_ready", 32'(core_ready), 32'd0);
    chk("arb_wdata_irq",  32'(mem_wdata),  32'h2222);
    tick();
    irq_push = 1'b0;
    #1;
    chk("arb_sp_irq",     32'(sp),         32'h37);
    chk("arb_core_ready2",32'(core_ready), 32'd1);
    chk("arb_addr_core",  32'(mem_addr),   32'h36);
    chk("arb_wdata_core", 32'(mem_wdata),  32'h3333);
    tick();
    core_call = 1'b0;
    #1;
    chk("arb_sp_core", 32'(sp), 32'h36);
    do_pop(1'b0, 19'h3333);
    do_pop(1'b1, 19'h2222);
    chk("after_pops_sp", 32'(sp), 32'h38);

    // 4: pop from empty
    do_pop(1'b0, 19'h0);
    chk("unf_set",   32'(unf_err), 32'd1);
    chk("unf_sp",    32'(sp),      32'h38);
    chk("unf_ovf",   32'(ovf_err), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("unf_clr",   32'(unf_err), 32'd0);

    // 5: small stack fills after two pushes
    s_push(19'h11);
    s_push(19'h22);
    chk("s_sp_full", 32'(s_sp),   32'h00);
    chk("s_full",    32'(s_full), 32'd1);
    s_core_call = 1'b1; s_core_wdata = 19'h33;
    #1;
    chk("s_ovf_we",  32'(s_mem_we), 32'd0);
    tick();
    s_core_call = 1'b0;
    chk("s_ovf_err", 32'(s_ovf_err), 32'd1);
    chk("s_ovf_sp",  32'(s_sp),      32'h00);
    s_core_ret = 1'b1;
    s_exp_q.push_back('{data: 19'h22, dst: 1'b0});
    tick();
    s_core_ret = 1'b0;
    tick();
    chk("s_pop_sp",  32'(s_sp), 32'h01);

    // 6: reset in the RD cycle aborts the pop
    core_call = 1'b1; core_wdata = 19'h5555;
    tick();
    core_call = 1'b0;
    core_ret  = 1'b1;
    tick();
    core_ret  = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_rd_sp",    32'(sp),        32'h38);
    chk("rst_rd_valid", 32'(pop_valid), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rd_sp2",   32'(sp), 32'h38);

    chk("scoreboard_drained",   32'(exp_q.size()),   32'd0);
    chk("s_scoreboard_drained", 32'(s_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
